// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32 core: program counter, instruction memory address,
// and the IF/ID register (instruction, PC, PC+4, valid).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds misalign_o and an ERROR
// state that traps redirects to targets that are not word aligned. Without it,
// redirect target bits [1:0] are forced to zero.
//
// Handshake: there is no backpressure handshake on IF/ID. valid_o marks a real
// instruction, stall_i holds PC and IF/ID for the cycle it is high, and
// redirect_i (which outranks stall_i) flushes IF/ID and loads the new PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        halted_o,
  output logic [1:0]  fsm_state
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, ERROR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
  logic        bad_target;
  assign bad_target = |redirect_pc_i[1:0];
`endif

  // Redirect targets are always word aligned when loaded into the PC.
  assign target = redirect_pc_i & 32'hFFFF_FFFC;

  // Next-state, next-PC and IF/ID update; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      BOOT: begin
        // Single bubble cycle; stall and redirect are ignored here.
        valid_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (bad_target) begin
            misalign_d = 1'b1;
            state_d    = ERROR;
          end else begin
            pc_d = target;
          end
`else
          pc_d = target;
`endif
        end else if (stall_i) begin
          // hold everything
        end else if (HALT_ON_ZERO && imem_rdata_i == 32'h0) begin
          // End-of-program marker: flush and park the PC on it.
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = HALT;
        end else begin
          instr_d = imem_rdata_i;
          pc_id_d = pc_q;
          pc4_d   = pc_q + 32'd4;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      HALT: begin
        // Only a redirect (e.g. a jal already downstream) restarts fetch.
        valid_d = 1'b0;
        if (redirect_i) begin
          instr_d = NOP_WORD;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (bad_target) begin
            misalign_d = 1'b1;
            state_d    = ERROR;
          end else begin
            pc_d    = target;
            state_d = RUN;
          end
`else
          pc_d    = target;
          state_d = RUN;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ERROR: begin
        // Sticky until reset.
        valid_d = 1'b0;
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  // State, PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc_id_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_id_q;
  assign pc_plus4_o  = pc4_q;
  assign valid_o     = valid_q;
  assign fsm_state   = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_o  = misalign_q;
  assign halted_o    = (state_q == HALT) || (state_q == ERROR);
`else
  assign halted_o    = (state_q == HALT);
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the RV32 core. Holds the program counter, drives the instruction memory address, and captures the returned word into an IF/ID register together with the PC and PC+4. It handles stall, branch/jump redirect, and halting when the memory returns the all-zero word that marks the end of the program. The instruction memory is combinational: it sees the address and returns the word in the same cycle.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_WORD, 32'h00000013, encoding (addi x0,x0,0) placed in IF/ID when it holds a bubble.
HALT_ON_ZERO, 1, 1 = a fetched word equal to 32'h0 halts fetch; 0 = the zero word is passed through as a normal instruction.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous reset, active-low
stall_i  in  1  hold PC and IF/ID this cycle
redirect_i  in  1  branch/jump taken; load redirect_pc_i
redirect_pc_i  in  32  redirect target
imem_addr_o  out  32  address to instruction memory (= pc_q, combinational)
imem_rdata_i  in  32  word returned by instruction memory, same cycle
instr_o  out  32  IF/ID instruction
pc_o  out  32  IF/ID PC of instr_o
pc_plus4_o  out  32  IF/ID pc_o+4 (for jal/jalr link)
valid_o  out  1  IF/ID holds a real instruction
halted_o  out  1  fetch is in HALT
misalign_o  out  1  only with FETCH_MISALIGN_TRAP_EN; misaligned redirect trapped

Behaviour:
- Reset (rst_n=0 at a clock edge) sets outputs as follows: pc_q=RESET_PC, instr_o=NOP_WORD, pc_o=0, pc_plus4_o=0, valid_o=0, halted_o=0, misalign_o=0, state=BOOT. Reset mid-operation discards any stall, redirect or halt.
- States and transitions:
  - BOOT: one bubble cycle. valid_o stays 0 and the PC does not advance. Next state is RUN unconditionally; stall_i and redirect_i are ignored in BOOT.
  - RUN, per clock edge, with priority redirect_i > stall_i > normal:
    - redirect_i=1: pc_q <= {redirect_pc_i[31:2],2'b00}; flush IF/ID (instr_o=NOP_WORD, valid_o=0; pc_o and pc_plus4_o hold). Redirect wins over a simultaneous stall.
    - stall_i=1: pc_q and all IF/ID outputs hold.
    - normal, with HALT_ON_ZERO=1 and imem_rdata_i==0: state goes to HALT; IF/ID is flushed as for a redirect; pc_q holds at the zero address.
    - normal, otherwise: instr_o<=imem_rdata_i, pc_o<=pc_q, pc_plus4_o<=pc_q+4, valid_o<=1, pc_q<=pc_q+4.
  - HALT: halted_o=1, valid_o=0, pc_q holds, stall_i is ignored. redirect_i=1 loads the target as in RUN and returns to RUN with halted_o cleared on the same edge. This covers a jal still in flight downstream when the end-of-program zero word is fetched.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0.
- Latency: a word at address A appears on instr_o one cycle after imem_addr_o=A with no stall. Redirect-to-valid latency is 2 cycles: the flush edge, then the capture edge.
- imem_addr_o always equals pc_q, including in BOOT and HALT.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - redirect_i with redirect_pc_i[1:0]!=0, in RUN or HALT, sets misalign_o=1, flushes IF/ID and enters ERROR; pc_q holds.
  - ERROR is exited only by reset. In ERROR, valid_o=0, halted_o=1, and all other inputs are ignored.
- Undefined:
  - The misalign_o port and the ERROR state do not exist.
  - Target bits [1:0] are silently forced to 0.

Test Plan:
- Reset release with RESET_PC=0, memory returning addi words -> one cycle valid_o=0 (BOOT); then instr_o=32'h00000013, pc_o=0, pc_plus4_o=4, valid_o=1; imem_addr_o steps 0x04, 0x08, 0x0C on successive cycles.
- stall_i=1 for 3 cycles at pc_q=0x3C -> imem_addr_o stays 0x3C and IF/ID holds the 0x38 word; stall released -> instr_o=32'h0FF00603, pc_o=0x3C.
- redirect_i=1, redirect_pc_i=0x50, asserted together with stall_i=1 at pc_q=0xAC -> next cycle pc_q=0x50, valid_o=0; the cycle after, instr_o=32'h04010E63, pc_o=0x50.
- Fetch reaches 0xAC where memory returns 0, HALT_ON_ZERO=1 -> halted_o=1, valid_o=0, pc_q=0xAC held. A redirect to 0x50 one cycle later -> halted_o=0 and fetch resumes at 0x50.
- Drive rst_n=0 for one edge while in HALT with stall_i=1 -> all outputs return to reset values, and BOOT then RUN restart from RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc_i=0x52 -> misalign_o=1, halted_o=1, valid_o=0; further redirects are ignored until reset. Without the macro, the same stimulus fetches from 0x50.
